// File: rtl/diff_bcd_pkg.sv
// Shared types and sizing for the subtractor-difference to sign+BCD formatter.
package diff_bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int DIGIT_W = 4;
    localparam int MAG_W   = 4;
    localparam int ITERS   = 4;
    localparam int SR_W    = 2*DIGIT_W + MAG_W;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
    import diff_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(5))
            dout = din + DIGIT_W'(3);
    end

endmodule

// File: rtl/diff_bcd_formatter.sv
// Converts a 4-bit subtractor result (diff, cout) into sign + two BCD digits with a
// sequential double-dabble, valid/ready on both sides, and a saturating negative counter.
module diff_bcd_formatter
    import diff_bcd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAG_W-1:0]   diff,
    input  logic               cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_neg,
    output logic [DIGIT_W-1:0] out_tens,
    output logic [DIGIT_W-1:0] out_ones,
    output logic [CNT_W-1:0]   neg_count
);

    state_t             state, state_nxt;
    logic [1:0]         iter;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_shift;
    logic               neg_r;
    logic [DIGIT_W-1:0] tens_adj, ones_adj;
    logic [MAG_W-1:0]   mag_in;
    logic               neg_in;
    logic               accept;
    logic               last_iter;

    // cout=0 means a borrow occurred, so the magnitude is the two's-complement negation.
    assign mag_in    = cout ? diff : (~diff + MAG_W'(1));
    assign neg_in    = ~cout & (mag_in != '0);
    assign accept    = in_valid & in_ready;
    assign last_iter = (iter == 2'(ITERS-1));

    bcd_add3 u_tens (.din(sr[SR_W-1 -: DIGIT_W]),  .dout(tens_adj));
    bcd_add3 u_ones (.din(sr[MAG_W +: DIGIT_W]),   .dout(ones_adj));

    assign sr_shift = {tens_adj, ones_adj, sr[MAG_W-1:0]} << 1;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    state_nxt = CONV;
            end
            CONV: begin
                if (last_iter)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            iter      <= '0;
            sr        <= '0;
            neg_r     <= 1'b0;
            out_neg   <= 1'b0;
            out_tens  <= '0;
            out_ones  <= '0;
            neg_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr    <= {{(2*DIGIT_W){1'b0}}, mag_in};
                        iter  <= '0;
                        neg_r <= neg_in;
                        if (neg_in && (neg_count != '1))
                            neg_count <= neg_count + CNT_W'(1);
                    end
                end
                CONV: begin
                    sr   <= sr_shift;
                    iter <= iter + 2'd1;
                    // Output registers only move on the edge that enters DONE.
                    if (last_iter) begin
                        out_tens <= sr_shift[SR_W-1 -: DIGIT_W];
                        out_ones <= sr_shift[MAG_W +: DIGIT_W];
                        out_neg  <= neg_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_bcd_formatter.sv
// Randomized and directed bench for diff_bcd_formatter against an arithmetic reference.
module tb_diff_bcd_formatter;

    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       cout = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] diff = 4'd0;

    logic             in_ready, out_valid, out_neg;
    logic [3:0]       out_tens, out_ones;
    logic [CNT_W-1:0] neg_count;

    logic       in_ready2, out_valid2, out_neg2;
    logic [3:0] out_tens2, out_ones2;
    logic [1:0] neg_count2;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_model = 0;
    int cnt2_model = 0;

    always #5 clk = ~clk;

    diff_bcd_formatter #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .diff(diff), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_neg(out_neg), .out_tens(out_tens), .out_ones(out_ones), .neg_count(neg_count)
    );

    diff_bcd_formatter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .diff(diff), .cout(cout), .out_valid(out_valid2), .out_ready(out_ready),
        .out_neg(out_neg2), .out_tens(out_tens2), .out_ones(out_ones2), .neg_count(neg_count2)
    );

    // Reference: signed value A-B recovered from diff/cout, then plain decimal split.
    task automatic ref_fmt(input logic [3:0] d, input logic c,
                           output logic n, output logic [3:0] t, output logic [3:0] o);
        int v, m;
        v = c ? int'(d) : int'(d) - 16;
        m = (v < 0) ? -v : v;
        m = m % 16;
        n = (v < 0) && (m != 0);
        t = 4'(m / 10);
        o = 4'(m % 10);
    endtask

    task automatic count_neg(input logic n);
        if (n) begin
            cnt_model  = (cnt_model  < (1 << CNT_W) - 1) ? cnt_model + 1 : cnt_model;
            cnt2_model = (cnt2_model < 3) ? cnt2_model + 1 : cnt2_model;
        end
    endtask

    // Drives one operand through acceptance and waits (bounded) for out_valid.
    task automatic run_op(input logic [3:0] d, input logic c, output int lat, output logic ir_acc,
                          output logic [CNT_W-1:0] cnt_acc, output logic [1:0] cnt2_acc);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        diff = d; cout = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ir_acc = in_ready; cnt_acc = neg_count; cnt2_acc = neg_count2;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic drain(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_neg !== 1'b0 || out_tens !== 4'd0 ||
            out_ones !== 4'd0 || neg_count !== '0) begin
            n_bad++;
            $display("FAIL reset_state: ir=%b ov=%b neg=%b t=%0d o=%0d cnt=%0d required ir=1 rest 0",
                     in_ready, out_valid, out_neg, out_tens, out_ones, neg_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt_model = 0; cnt2_model = 0;
    endtask

    task automatic test_vectors;
        logic [3:0] td [6] = '{4'b1010, 4'b1110, 4'b0001, 4'b1111, 4'b0000, 4'b0000};
        logic       tc [6] = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0};
        logic [8:0] te [6] = '{9'h010,  9'h102,  9'h115,  9'h015,  9'h000,  9'h000};
        int lat; logic ir; logic [CNT_W-1:0] cnt; logic [1:0] cnt2;
        for (int i = 0; i < 6; i++) begin
            count_neg(te[i][8]);
            run_op(td[i], tc[i], lat, ir, cnt, cnt2);
            n_cmp++;
            if (lat != 4 || ir !== 1'b0) begin
                n_bad++;
                $display("FAIL vec%0d_latency: lat=%0d ir_after_accept=%b required 4/0", i, lat, ir);
            end
            n_cmp++;
            if ({out_neg, out_tens, out_ones} !== te[i]) begin
                n_bad++;
                $display("FAIL vec%0d_result: got %h required %h", i, {out_neg, out_tens, out_ones}, te[i]);
            end
            n_cmp++;
            if (int'(cnt) != cnt_model) begin
                n_bad++;
                $display("FAIL vec%0d_neg_count: got %0d required %0d", i, cnt, cnt_model);
            end
            drain(i % 2);
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL vec%0d_return_idle: ir=%b ov=%b required 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] exp_res = 9'h110;   // diff=0110, cout=0 -> -10
        int held;
        diff = 4'b0110; cout = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        count_neg(1'b1);
        for (int i = 0; i < 4; i++) begin
            diff = 4'($urandom); cout = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== (i == 3)) begin
                n_bad++;
                $display("FAIL conv_ignore%0d: ir=%b ov=%b required 0/%0d", i, in_ready, out_valid, i == 3);
            end
        end
        held = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); diff = 4'($urandom); cout = 1'($urandom);
            @(posedge clk); #1;
            if (out_valid === 1'b1 && in_ready === 1'b0 && {out_neg, out_tens, out_ones} === exp_res &&
                int'(neg_count) == cnt_model)
                held++;
        end
        n_cmp++;
        if (held != 10) begin
            n_bad++;
            $display("FAIL backpressure_hold: stable cycles=%0d required 10 (now %h cnt=%0d, required %h cnt=%0d)",
                     held, {out_neg, out_tens, out_ones}, neg_count, exp_res, cnt_model);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || int'(neg_count) != cnt_model) begin
            n_bad++;
            $display("FAIL release_idle: ir=%b ov=%b cnt=%0d required 1/0/%0d", in_ready, out_valid,
                     neg_count, cnt_model);
        end
    endtask

    task automatic test_reset_midconv;
        int lat; logic ir; logic [CNT_W-1:0] cnt; logic [1:0] cnt2;
        diff = 4'b1101; cout = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        cnt_model = 0; cnt2_model = 0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_neg !== 1'b0 || out_tens !== 4'd0 ||
            out_ones !== 4'd0 || neg_count !== '0) begin
            n_bad++;
            $display("FAIL reset_midconv: ir=%b ov=%b neg=%b t=%0d o=%0d cnt=%0d required ir=1 rest 0",
                     in_ready, out_valid, out_neg, out_tens, out_ones, neg_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'b1001, 1'b1, lat, ir, cnt, cnt2);
        n_cmp++;
        if (lat != 4 || {out_neg, out_tens, out_ones} !== 9'h009 || cnt !== '0) begin
            n_bad++;
            $display("FAIL post_reset_op: lat=%0d res=%h cnt=%0d required 4/009/0", lat,
                     {out_neg, out_tens, out_ones}, cnt);
        end
        drain(0);
    endtask

    task automatic test_saturation;
        logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        int lat; logic ir; logic [CNT_W-1:0] cnt; logic [1:0] cnt2;
        for (int i = 0; i < 5; i++) begin
            run_op(4'($urandom_range(1, 15)), 1'b0, lat, ir, cnt, cnt2);
            count_neg(1'b1);
            n_cmp++;
            if (cnt2 !== exp2[i] || int'(cnt) != i + 1) begin
                n_bad++;
                $display("FAIL sat%0d: cnt2=%0d cnt=%0d required %0d/%0d", i, cnt2, cnt, exp2[i], i + 1);
            end
            drain(0);
        end
    endtask

    task automatic test_back_to_back;
        logic n; logic [3:0] t, o;
        logic [3:0] d; logic c;
        int last, nvalid, bad;
        d = 4'($urandom); c = 1'($urandom);
        ref_fmt(d, c, n, t, o);
        diff = d; cout = c; in_valid = 1'b1; out_ready = 1'b1;
        last = -1; nvalid = 0; bad = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if ((last < 0 && cyc != 5) || (last >= 0 && cyc - last != 6) ||
                    {out_neg, out_tens, out_ones} !== {n, t, o})
                    bad++;
                last = cyc; nvalid++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (5) count_neg(n);
        n_cmp++;
        if (nvalid != 5 || bad != 0) begin
            n_bad++;
            $display("FAIL back_to_back: results=%0d bad_spacing_or_data=%0d required 5/0", nvalid, bad);
        end
        n_cmp++;
        if (int'(neg_count) != cnt_model || int'(neg_count2) != cnt2_model) begin
            n_bad++;
            $display("FAIL b2b_neg_count: got %0d/%0d required %0d/%0d", neg_count, neg_count2,
                     cnt_model, cnt2_model);
        end
    endtask

    task automatic test_random;
        logic n; logic [3:0] t, o;
        logic [3:0] d; logic c;
        int lat; logic ir; logic [CNT_W-1:0] cnt; logic [1:0] cnt2;
        for (int i = 0; i < 200; i++) begin
            d = 4'($urandom); c = 1'($urandom);
            ref_fmt(d, c, n, t, o);
            count_neg(n);
            run_op(d, c, lat, ir, cnt, cnt2);
            n_cmp++;
            if (lat != 4 || ir !== 1'b0 || {out_neg, out_tens, out_ones} !== {n, t, o} ||
                int'(cnt) != cnt_model || int'(cnt2) != cnt2_model) begin
                n_bad++;
                $display("FAIL rand%0d d=%b c=%b: lat=%0d ir=%b res=%h cnt=%0d/%0d required 4/0/%h cnt=%0d/%0d",
                         i, d, c, lat, ir, {out_neg, out_tens, out_ones}, cnt, cnt2, {n, t, o},
                         cnt_model, cnt2_model);
            end
            drain($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_backpressure;
        test_reset_midconv;
        test_saturation;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
